w4823_coef_loader: RTL and testbench
====================================

// Module: w4823_coef_loader
// PURPOSE
//   Upstream feeder for the W4823 FIR coefficient port. Accepts a byte stream (3 bytes per
//   17-bit coefficient, then 1 XOR checksum byte) and writes NUM_TAPS coefficients sequentially
//   into the FIR via cin/caddr/cload. Runs entirely on clk_fast, the same clock as the FIR's
//   clk2 port. Reports busy, done and a sticky error flag.
// PARAMETERS
//   NUM_TAPS  64  coefficients per load; taps are written to addresses 0..NUM_TAPS-1
//   ADDR_W    6   caddr width; must satisfy 2**ADDR_W >= NUM_TAPS
//   COEF_W    17  coefficient width, fixed by the FIR cin port
// PORTS
//   clk_fast    in   1       fast clock (FIR clk2)
//   rst_n       in   1       asynchronous, active-low reset
//   start       in   1       1-cycle request to begin a load; ignored while busy
//   abort       in   1       cancels a load in progress
//   byte_in     in   8       stream data
//   byte_valid  in   1       byte_in is valid
//   byte_ready  out  1       loader accepts byte_in this cycle
//   cin         out  17      coefficient to FIR
//   caddr       out  ADDR_W  coefficient address to FIR
//   cload       out  1       1-cycle write strobe to FIR
//   busy        out  1       load in progress
//   done        out  1       1-cycle pulse when a load completes or is aborted
//   err         out  1       sticky error; cleared by the next accepted start
// BEHAVIOUR
//   Reset: all outputs 0. FSM enters IDLE. Tap index, byte registers and XOR accumulator cleared.
//   Reset asserted mid-load ends the load immediately. No cload is issued after reset.
//   A byte is accepted on a clk_fast edge when byte_valid && byte_ready.
//   FSM states and transitions:
//     IDLE: byte_ready=0, busy=0. On start, go to B0.
//       Same edge as start: idx=0, xor=0, err=0, busy=1.
//       Bytes presented in IDLE are not accepted and are not an error.
//     B0: byte_ready=1. Captures byte 0 (MS byte); only bit 0 is coefficient data.
//       Bits [7:1] nonzero sets err=1, but the load continues. Goes to B1.
//     B1: byte_ready=1. Captures byte 1 (coefficient bits [15:8]). Goes to B2.
//     B2: byte_ready=1. Captures byte 2 (coefficient bits [7:0]). Goes to WR.
//     WR: byte_ready=0. Asserts cload=1 for exactly one cycle.
//       cin={b0[0],b1,b2}; caddr=idx.
//       If idx==NUM_TAPS-1, go to CHK; otherwise idx+1 and go to B0.
//     CHK: byte_ready=1. On accept, compares the byte with xor, the XOR of all 3*NUM_TAPS data bytes.
//       Mismatch sets err=1. Goes to FIN.
//     FIN: done=1 for 1 cycle; busy falls to 0 on the same edge that done rises. Goes to IDLE.
//   Running xor is updated by every byte accepted in B0, B1 and B2. The checksum byte is not included.
//   cin and caddr hold the last written values between strobes and after the load. They are not cleared.
//   Minimum rate: 4 clk_fast cycles per coefficient (3 byte cycles + 1 WR cycle).
//   byte_valid gaps stall the FSM in its current B state indefinitely. No timeout.
//   abort in B0, B1, B2, WR or CHK: go to FIN next cycle with err=1.
//     Partial bytes are discarded and no further cload is issued.
//     If abort and the WR strobe coincide, the WR strobe still completes; abort takes effect next cycle.
//   start with abort in IDLE: start wins and abort is ignored.
//   start while busy: ignored; err unchanged.
// TESTING
//   1. Ramp load: coefficient k=k for k=0..63, correct checksum, byte_valid held high
//      -> 64 cload pulses, caddr 0..63, cin=k, 4-cycle spacing, done pulse, err=0.
//   2. Bad checksum: same stream with checksum XOR 8'h01 -> all 64 cloads, done, err=1.
//   3. Coefficient 17'h1FFFF = bytes 01 FF FF at tap 5 -> cin=17'h1FFFF at caddr=5.
//      Byte0=8'h03 at tap 6 -> err=1, cin[16]=1.
//   4. Backpressure: random byte_valid gaps of 0-7 cycles -> same cload sequence as test 1.
//      Each byte accepted exactly once.
//   5. abort after tap 10's second byte -> exactly 10 cloads (caddr 0..9), done, err=1.
//      A following start clears err and reloads from caddr=0.
//   6. rst_n low during tap 20 -> all outputs 0 asynchronously, no further cload.
//      A second start during a load has no effect.

Source files
------------

// File: rtl/w4823_coef_loader_if.sv
// W4823 coefficient loader bus.
// Byte stream in, FIR coefficient write port and status out.
interface w4823_coef_loader_if #(
    parameter int ADDR_W = 6,
    parameter int COEF_W = 17
);
    logic              start;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [COEF_W-1:0] cin;
    logic [ADDR_W-1:0] caddr;
    logic              cload;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, byte_in, byte_valid,
        input  byte_ready, cin, caddr, cload, busy, done, err
    );

    modport slave (
        input  start, abort, byte_in, byte_valid,
        output byte_ready, cin, caddr, cload, busy, done, err
    );
endinterface

// File: rtl/w4823_coef_loader.sv
// W4823 FIR coefficient loader.
// Packs 3 bytes per coefficient, writes taps, verifies XOR checksum.
module w4823_coef_loader #(
    parameter int NUM_TAPS = 64,
    parameter int ADDR_W   = 6,
    parameter int COEF_W   = 17
) (
    input  logic                  clk_fast,
    input  logic                  rst_n,
    w4823_coef_loader_if.slave    bus
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_WR,
        S_CHK,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [7:0]        xor_q, xor_d;
    logic              err_q, err_d;
    logic [COEF_W-1:0] cin_q, cin_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic              byte_ready;
    logic              accept;

    assign accept = bus.byte_valid && byte_ready;

    // Next-state and datapath updates; abort beats a byte in the same cycle
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        xor_d      = xor_q;
        err_d      = err_q;
        cin_d      = cin_q;
        caddr_d    = caddr_q;
        byte_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_B0;
                    idx_d   = '0;
                    xor_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_B0: begin
                byte_ready = 1'b1;
                if (bus.abort) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else if (accept) begin
                    b0_d    = bus.byte_in[0];
                    xor_d   = xor_q ^ bus.byte_in;
                    state_d = S_B1;
                    if (|bus.byte_in[7:1]) err_d = 1'b1;
                end
            end
            S_B1: begin
                byte_ready = 1'b1;
                if (bus.abort) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else if (accept) begin
                    b1_d    = bus.byte_in;
                    xor_d   = xor_q ^ bus.byte_in;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                byte_ready = 1'b1;
                if (bus.abort) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else if (accept) begin
                    cin_d   = {b0_q, b1_q, bus.byte_in};
                    caddr_d = idx_q;
                    xor_d   = xor_q ^ bus.byte_in;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (bus.abort) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else if (idx_q == LAST) begin
                    state_d = S_CHK;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_B0;
                end
            end
            S_CHK: begin
                byte_ready = 1'b1;
                if (bus.abort) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else if (accept) begin
                    if (bus.byte_in != xor_q) err_d = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            b0_q    <= 1'b0;
            b1_q    <= '0;
            xor_q   <= '0;
            err_q   <= 1'b0;
            cin_q   <= '0;
            caddr_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            xor_q   <= xor_d;
            err_q   <= err_d;
            cin_q   <= cin_d;
            caddr_q <= caddr_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.cin        = cin_q;
    assign bus.caddr      = caddr_q;
    assign bus.cload      = (state_q == S_WR);
    assign bus.done       = (state_q == S_FIN);
    assign bus.busy       = (state_q != S_IDLE) &&
                            (state_q != S_FIN);
    assign bus.err        = err_q;

endmodule

// File: tb/tb_w4823_coef_loader.sv
// Bench for w4823_coef_loader.
// Random streams checked against a tap-list reference model.
module tb_w4823_coef_loader;

    localparam int NUM_TAPS = 64;
    localparam int ADDR_W   = 6;
    localparam int COEF_W   = 17;

    logic clk_fast = 1'b0;
    logic rst_n    = 1'b0;

    always #5 clk_fast = ~clk_fast;

    w4823_coef_loader_if #(.ADDR_W(ADDR_W), .COEF_W(COEF_W)) bus ();

    w4823_coef_loader #(
        .NUM_TAPS(NUM_TAPS),
        .ADDR_W  (ADDR_W),
        .COEF_W  (COEF_W)
    ) dut (
        .clk_fast(clk_fast),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and write-strobe / byte-accept monitors
    int cyc     = 0;
    int acc_cnt = 0;
    logic [ADDR_W-1:0] ld_addr[$];
    logic [COEF_W-1:0] ld_coef[$];
    int                ld_cyc[$];

    always @(posedge clk_fast) begin
        cyc <= cyc + 1;
        if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1)
            acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk_fast) begin
        if (bus.cload === 1'b1) begin
            ld_addr.push_back(bus.caddr);
            ld_coef.push_back(bus.cin);
            ld_cyc.push_back(cyc);
        end
    end

    // Reference data: coefficient per tap, junk bits in byte 0
    logic [COEF_W-1:0] coef[NUM_TAPS];
    logic [6:0]        hi[NUM_TAPS];
    logic [7:0]        stream[$];
    bit                exp_err;

    task automatic build(input bit bad_ck);
        logic [7:0] x, b0, b1, b2;
        stream.delete();
        x       = 8'h00;
        exp_err = 1'b0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            b0 = {hi[k], coef[k][16]};
            b1 = coef[k][15:8];
            b2 = coef[k][7:0];
            stream.push_back(b0);
            stream.push_back(b1);
            stream.push_back(b2);
            x = x ^ b0 ^ b1 ^ b2;
            if (hi[k] != 7'd0) exp_err = 1'b1;
        end
        stream.push_back(bad_ck ? (x ^ 8'h01) : x);
        if (bad_ck) exp_err = 1'b1;
    endtask

    task automatic ramp();
        for (int k = 0; k < NUM_TAPS; k++) begin
            coef[k] = COEF_W'(k);
            hi[k]   = 7'd0;
        end
    endtask

    task automatic rand_coefs();
        for (int k = 0; k < NUM_TAPS; k++) begin
            coef[k] = COEF_W'($urandom);
            hi[k]   = 7'd0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) @(negedge clk_fast);
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 100) begin
            @(negedge clk_fast);
            t++;
        end
        if (bus.byte_ready !== 1'b1)
            check("byte_ready_timeout", 32'(bus.byte_ready), 32'd1);
        else
            @(negedge clk_fast);
    endtask

    task automatic run_stream(input int max_gap, input int n_bytes,
                              input int start_at);
        for (int i = 0; i < n_bytes; i++) begin
            if (i == start_at) bus.start = 1'b1;
            send_byte(stream[i],
                      max_gap > 0 ? int'($urandom_range(max_gap, 0)) : 0);
            bus.start = 1'b0;
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit with_abort);
        bus.start = 1'b1;
        bus.abort = with_abort;
        @(negedge clk_fast);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_fast);
        end
    endtask

    task automatic check_loads(input string tag, input int base,
                               input int n);
        int got;
        got = ld_addr.size() - base;
        check({tag, "_count"}, 32'(got), 32'(n));
        for (int k = 0; k < n && k < got; k++) begin
            check({tag, "_caddr"}, 32'(ld_addr[base+k]), 32'(k));
            check({tag, "_cin"}, 32'(ld_coef[base+k]), 32'(coef[k]));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_cload"}, 32'(bus.cload), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
        check({tag, "_cin"}, 32'(bus.cin), 32'd0);
        check({tag, "_caddr"}, 32'(bus.caddr), 32'd0);
    endtask

    task automatic full_load(input string tag, input int max_gap,
                             input bit spacing);
        int  base, a0, bad;
        bit  seen;
        base = ld_addr.size();
        a0   = acc_cnt;
        pulse_start(1'b0);
        check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        run_stream(max_gap, stream.size(), -1);
        wait_done(seen);
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        check_loads(tag, base, NUM_TAPS);
        check({tag, "_accepted"}, 32'(acc_cnt - a0),
              32'(3 * NUM_TAPS + 1));
        if (spacing) begin
            bad = 0;
            for (int k = 1; k < NUM_TAPS; k++)
                if (base + k < ld_cyc.size() &&
                    ld_cyc[base+k] - ld_cyc[base+k-1] != 4) bad++;
            check({tag, "_spacing_errs"}, 32'(bad), 32'd0);
        end
        @(negedge clk_fast);
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int  base;
        bit  seen;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;

        repeat (3) @(negedge clk_fast);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk_fast);
        check_zero("idle");

        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hA5;
        base = acc_cnt;
        repeat (3) @(negedge clk_fast);
        bus.byte_valid = 1'b0;
        check("idle_no_accept", 32'(acc_cnt - base), 32'd0);
        check("idle_no_err", 32'(bus.err), 32'd0);

        ramp();
        build(1'b0);
        full_load("ramp", 0, 1'b1);

        build(1'b1);
        full_load("badck", 0, 1'b0);

        rand_coefs();
        coef[5] = 17'h1FFFF;
        coef[6][16] = 1'b1;
        hi[6] = 7'h01;
        build(1'b0);
        base = ld_addr.size();
        full_load("special", 0, 1'b0);
        if (base + 6 < ld_coef.size()) begin
            check("special_tap5", 32'(ld_coef[base+5]), 32'h1FFFF);
            check("special_tap6_b16", 32'(ld_coef[base+6][16]), 32'd1);
        end

        rand_coefs();
        build(1'b0);
        full_load("gaps", 7, 1'b0);

        ramp();
        build(1'b0);
        base = ld_addr.size();
        pulse_start(1'b0);
        run_stream(0, 10 * 3 + 2, -1);
        bus.abort = 1'b1;
        @(negedge clk_fast);
        bus.abort = 1'b0;
        wait_done(seen);
        check("abort_done", 32'(seen), 32'd1);
        check("abort_err", 32'(bus.err), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check_loads("abort", base, 10);
        @(negedge clk_fast);
        base = ld_addr.size();
        pulse_start(1'b1);
        check("restart_err_clr", 32'(bus.err), 32'd0);
        check("restart_busy", 32'(bus.busy), 32'd1);
        run_stream(0, stream.size(), -1);
        wait_done(seen);
        check("restart_done", 32'(seen), 32'd1);
        check("restart_err", 32'(bus.err), 32'd0);
        check_loads("restart", base, NUM_TAPS);
        @(negedge clk_fast);

        rand_coefs();
        build(1'b0);
        base = ld_addr.size();
        pulse_start(1'b0);
        run_stream(0, 20 * 3 + 1, 40);
        check("busy_start_err", 32'(bus.err), 32'd0);
        check("busy_start_busy", 32'(bus.busy), 32'd1);
        bus.byte_valid = 1'b1;
        bus.byte_in    = stream[61];
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        check_loads("midreset", base, 20);
        base = ld_addr.size();
        repeat (4) @(negedge clk_fast);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_fast);
        bus.byte_valid = 1'b0;
        check("post_reset_no_cload", 32'(ld_addr.size() - base), 32'd0);
        check("post_reset_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
